// File: rtl/clip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clip_sequencer
// Purpose  : Record/playback sequencer for a two-clip audio recorder. Owns the
//            shared BRAM address counter and the per-memory en/we strobes.
// Revision : 1.0 - initial release
// ============================================================================
module clip_sequencer #(
    parameter int ADDR_W     = 15,
    parameter int CLIP_DEPTH = 32768,
    parameter int SAMPLE_W   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                record_req,
    input  logic                play_req,
    input  logic                clip_sel_record,
    input  logic                clip_sel_play,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                play_tick,
    input  logic [SAMPLE_W-1:0] mem1_dout,
    input  logic [SAMPLE_W-1:0] mem2_dout,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [SAMPLE_W-1:0] mem_din,
    output logic                mem1_en,
    output logic                mem2_en,
    output logic                mem1_we,
    output logic                mem2_we,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_out_valid,
    output logic                recording,
    output logic                playing,
    output logic                active_clip,
    output logic [1:0]          clip_full
);

    // Lengths need one extra bit so a full clip (CLIP_DEPTH samples) is representable.
    localparam int                 LEN_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(CLIP_DEPTH - 1);
    localparam logic [LEN_W-1:0]   FULL_LEN  = LEN_W'(CLIP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } state_t;

    state_t                   state_q,       state_d;
    logic [ADDR_W-1:0]        addr_q,        addr_d;
    logic                     active_clip_q, active_clip_d;
    logic [1:0][LEN_W-1:0]    len_q,         len_d;
    logic [1:0]               clip_full_q,   clip_full_d;
    logic                     rd_pending_q,  rd_pending_d;
    logic                     rd_clip_q,     rd_clip_d;
    logic [SAMPLE_W-1:0]      held_q,        held_d;

    logic                     wr_now;
    logic                     rd_now;
    logic [SAMPLE_W-1:0]      rd_data;
    logic [LEN_W-1:0]         addr_ext;
    logic [LEN_W-1:0]         rec_count;

    // A stop request in PLAY takes priority over a same-cycle tick.
    assign wr_now    = (state_q == S_RECORD) && sample_valid && !reset;
    assign rd_now    = (state_q == S_PLAY) && play_tick && !play_req && !reset;
    assign rd_data   = rd_clip_q ? mem2_dout : mem1_dout;
    assign addr_ext  = {1'b0, addr_q};
    assign rec_count = addr_ext + LEN_W'(wr_now);

    assign mem_addr         = addr_q;
    assign mem_din          = wr_now ? sample_in : '0;
    assign mem1_en          = (wr_now || rd_now) && !active_clip_q;
    assign mem2_en          = (wr_now || rd_now) &&  active_clip_q;
    assign mem1_we          = wr_now && !active_clip_q;
    assign mem2_we          = wr_now &&  active_clip_q;
    assign sample_out       = rd_pending_q ? rd_data : held_q;
    assign sample_out_valid = rd_pending_q;
    assign recording        = (state_q == S_RECORD);
    assign playing          = (state_q == S_PLAY);
    assign active_clip      = (state_q != S_IDLE) && active_clip_q;
    assign clip_full        = clip_full_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        active_clip_d = active_clip_q;
        len_d         = len_q;
        clip_full_d   = clip_full_q;
        rd_pending_d  = rd_now;
        rd_clip_d     = active_clip_q;
        held_d        = rd_pending_q ? rd_data : held_q;

        case (state_q)
            S_IDLE: begin
                if (record_req) begin
                    state_d                      = S_RECORD;
                    active_clip_d                = clip_sel_record;
                    addr_d                       = '0;
                    clip_full_d[clip_sel_record] = 1'b0;
                end else if (play_req && (len_q[clip_sel_play] != '0)) begin
                    state_d       = S_PLAY;
                    active_clip_d = clip_sel_play;
                    addr_d        = '0;
                end
            end

            S_RECORD: begin
                if (wr_now && (addr_q == LAST_ADDR)) begin
                    len_d[active_clip_q]       = FULL_LEN;
                    clip_full_d[active_clip_q] = 1'b1;
                    state_d                    = S_IDLE;
                    addr_d                     = '0;
                end else if (record_req) begin
                    len_d[active_clip_q] = rec_count;
                    state_d              = S_IDLE;
                    addr_d               = '0;
                end else if (wr_now) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            S_PLAY: begin
                if (play_req) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (rd_now) begin
                    if ((addr_ext + LEN_W'(1)) == len_q[active_clip_q]) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            active_clip_q <= 1'b0;
            len_q         <= '0;
            clip_full_q   <= '0;
            rd_pending_q  <= 1'b0;
            rd_clip_q     <= 1'b0;
            held_q        <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            active_clip_q <= active_clip_d;
            len_q         <= len_d;
            clip_full_q   <= clip_full_d;
            rd_pending_q  <= rd_pending_d;
            rd_clip_q     <= rd_clip_d;
            held_q        <= held_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clip_sequencer
// Purpose  : Randomized + directed bench for clip_sequencer (CLIP_DEPTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clip_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 8;
    localparam int SW    = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          record_req = 1'b0, play_req = 1'b0;
    logic          clip_sel_record = 1'b0, clip_sel_play = 1'b0;
    logic          sample_valid = 1'b0, play_tick = 1'b0;
    logic [SW-1:0] sample_in = '0;
    logic [SW-1:0] mem1_dout = '0, mem2_dout = '0;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_din, sample_out;
    logic          mem1_en, mem2_en, mem1_we, mem2_we;
    logic          sample_out_valid, recording, playing, active_clip;
    logic [1:0]    clip_full;

    always #5 clock = ~clock;

    clip_sequencer #(.ADDR_W(AW), .CLIP_DEPTH(DEPTH), .SAMPLE_W(SW)) dut (
        .clock(clock), .reset(reset),
        .record_req(record_req), .play_req(play_req),
        .clip_sel_record(clip_sel_record), .clip_sel_play(clip_sel_play),
        .sample_valid(sample_valid), .sample_in(sample_in), .play_tick(play_tick),
        .mem1_dout(mem1_dout), .mem2_dout(mem2_dout),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem1_en(mem1_en), .mem2_en(mem2_en), .mem1_we(mem1_we), .mem2_we(mem2_we),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid),
        .recording(recording), .playing(playing), .active_clip(active_clip),
        .clip_full(clip_full)
    );

    // Two read-first BRAMs with one cycle of read latency.
    logic [SW-1:0] bram1 [16];
    logic [SW-1:0] bram2 [16];
    always @(posedge clock) begin
        if (mem1_en) begin
            if (mem1_we) bram1[mem_addr] <= mem_din;
            mem1_dout <= bram1[mem_addr];
        end
        if (mem2_en) begin
            if (mem2_we) bram2[mem_addr] <= mem_din;
            mem2_dout <= bram2[mem_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = idle, 1 = recording, 2 = playing.
    int       m_mode = 0, m_addr = 0, m_ac = 0;
    int       m_len [2];
    bit [1:0] m_full = '0;
    int       m_clip [2][DEPTH];
    bit       m_pend = 0;
    int       m_pend_val = 0, m_held = 0;
    bit       armed = 0;

    int       w1_cnt = 0, w2_cnt = 0, en_cnt = 0;
    int       wq_addr [$];
    int       wq_din  [$];
    int       outq    [$];

    always @(negedge clock) begin : cmp
        bit e_wr, e_rd, n_pend;
        int n_val, cnt;
        e_wr = !reset && m_mode == 1 && sample_valid;
        e_rd = !reset && m_mode == 2 && play_tick && !play_req;
        if (armed) begin
            chk("mem1_en", 32'(mem1_en), 32'((e_wr || e_rd) && m_ac == 0));
            chk("mem2_en", 32'(mem2_en), 32'((e_wr || e_rd) && m_ac == 1));
            chk("mem1_we", 32'(mem1_we), 32'(e_wr && m_ac == 0));
            chk("mem2_we", 32'(mem2_we), 32'(e_wr && m_ac == 1));
            if (e_wr || e_rd) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (e_wr) chk("mem_din", 32'(mem_din), 32'(sample_in));
            chk("sample_out_valid", 32'(sample_out_valid), 32'(m_pend));
            chk("sample_out", 32'(sample_out), m_pend ? m_pend_val : m_held);
            chk("recording", 32'(recording), 32'(m_mode == 1));
            chk("playing", 32'(playing), 32'(m_mode == 2));
            chk("active_clip", 32'(active_clip), (m_mode != 0) ? m_ac : 0);
            chk("clip_full", 32'(clip_full), 32'(m_full));
        end
        if (mem1_we) begin w1_cnt++; wq_addr.push_back(int'(mem_addr)); wq_din.push_back(int'(mem_din)); end
        if (mem2_we) begin w2_cnt++; wq_addr.push_back(int'(mem_addr)); wq_din.push_back(int'(mem_din)); end
        if (mem1_en || mem2_en) en_cnt++;
        if (sample_out_valid) outq.push_back(int'(sample_out));

        if (reset) begin
            m_mode = 0; m_addr = 0; m_ac = 0; m_len[0] = 0; m_len[1] = 0;
            m_full = '0; m_pend = 0; m_pend_val = 0; m_held = 0;
            armed = 1;
        end else if (armed) begin
            n_pend = e_rd;
            n_val  = e_rd ? m_clip[m_ac][m_addr] : 0;
            if (m_pend) m_held = m_pend_val;
            case (m_mode)
                0: begin
                    if (record_req) begin
                        m_mode = 1; m_ac = int'(clip_sel_record); m_addr = 0;
                        m_full[m_ac] = 1'b0;
                    end else if (play_req && m_len[int'(clip_sel_play)] != 0) begin
                        m_mode = 2; m_ac = int'(clip_sel_play); m_addr = 0;
                    end
                end
                1: begin
                    cnt = m_addr + (sample_valid ? 1 : 0);
                    if (sample_valid) m_clip[m_ac][m_addr] = int'(sample_in);
                    if (sample_valid && cnt == DEPTH) begin
                        m_len[m_ac] = DEPTH; m_full[m_ac] = 1'b1; m_mode = 0; m_addr = 0;
                    end else if (record_req) begin
                        m_len[m_ac] = cnt; m_mode = 0; m_addr = 0;
                    end else begin
                        m_addr = cnt;
                    end
                end
                default: begin
                    if (play_req) begin
                        m_mode = 0; m_addr = 0;
                    end else if (play_tick) begin
                        if (m_addr + 1 == m_len[m_ac]) begin m_mode = 0; m_addr = 0; end
                        else m_addr = m_addr + 1;
                    end
                end
            endcase
            m_pend = n_pend;
            m_pend_val = n_val;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_rec(input bit sel);
        record_req = 1'b1; clip_sel_record = sel; cyc(); record_req = 1'b0;
    endtask

    task automatic pulse_play(input bit sel);
        play_req = 1'b1; clip_sel_play = sel; cyc(); play_req = 1'b0;
    endtask

    task automatic send_sample(input logic [SW-1:0] v);
        sample_valid = 1'b1; sample_in = v; cyc(); sample_valid = 1'b0; cyc(2);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_recording"}, 32'(recording), 0);
        chk({tag, "_playing"}, 32'(playing), 0);
        chk({tag, "_active_clip"}, 32'(active_clip), 0);
        chk({tag, "_clip_full"}, 32'(clip_full), 0);
        chk({tag, "_sample_out"}, 32'(sample_out), 0);
        chk({tag, "_sample_out_valid"}, 32'(sample_out_valid), 0);
        chk({tag, "_en"}, 32'({mem1_en, mem2_en, mem1_we, mem2_we}), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    endtask

    int en0;

    initial begin
        cyc(3);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("reset");

        // Record five samples into clip 0, then stop.
        cyc();
        w1_cnt = 0; w2_cnt = 0; wq_addr.delete(); wq_din.delete();
        pulse_rec(1'b0);
        for (int i = 1; i <= 5; i++) send_sample(SW'(i));
        pulse_rec(1'b0);
        cyc(2);
        chk("rec0_w1_cnt", 32'(w1_cnt), 5);
        chk("rec0_w2_cnt", 32'(w2_cnt), 0);
        chk("rec0_nwrites", 32'(wq_addr.size()), 5);
        for (int i = 0; i < 5 && i < wq_addr.size(); i++) begin
            chk("rec0_addr", 32'(wq_addr[i]), 32'(i));
            chk("rec0_din", 32'(wq_din[i]), 32'(i + 1));
        end
        chk("rec0_recording", 32'(recording), 0);
        chk("rec0_model_len", 32'(m_len[0]), 5);

        // Play clip 0 with a tick every 4 cycles.
        outq.delete();
        pulse_play(1'b0);
        for (int i = 0; i < 7; i++) begin
            play_tick = 1'b1; cyc(); play_tick = 1'b0; cyc(3);
        end
        chk("play0_nout", 32'(outq.size()), 5);
        for (int i = 0; i < 5 && i < outq.size(); i++)
            chk("play0_value", 32'(outq[i]), 32'(i + 1));
        chk("play0_playing", 32'(playing), 0);

        // Play on empty clip 1 is ignored.
        en0 = en_cnt;
        pulse_play(1'b1);
        play_tick = 1'b1; cyc(3); play_tick = 1'b0;
        chk("empty_playing", 32'(playing), 0);
        chk("empty_en", 32'(en_cnt - en0), 0);

        // Simultaneous record/play: record wins; then overfill clip 1.
        record_req = 1'b1; play_req = 1'b1; clip_sel_record = 1'b1; clip_sel_play = 1'b0;
        cyc();
        record_req = 1'b0; play_req = 1'b0;
        @(negedge clock);
        chk("both_recording", 32'(recording), 1);
        chk("both_playing", 32'(playing), 0);
        chk("both_active", 32'(active_clip), 1);
        cyc();
        w1_cnt = 0; w2_cnt = 0; wq_addr.delete(); wq_din.delete();
        for (int i = 0; i < 10; i++) send_sample(SW'(16'h0100 + i));
        cyc(2);
        chk("full_w2_cnt", 32'(w2_cnt), 8);
        chk("full_w1_cnt", 32'(w1_cnt), 0);
        chk("full_clip_full", 32'(clip_full), 32'h2);
        chk("full_recording", 32'(recording), 0);
        for (int i = 0; i < 8 && i < wq_addr.size(); i++) begin
            chk("full_addr", 32'(wq_addr[i]), 32'(i));
            chk("full_din", 32'(wq_din[i]), 32'(16'h0100 + i));
        end

        // Reset in the middle of playback.
        pulse_rec(1'b0);
        send_sample(16'h0007); send_sample(16'h0008); send_sample(16'h0009);
        pulse_rec(1'b0);
        pulse_play(1'b0);
        play_tick = 1'b1; cyc(); play_tick = 1'b0;
        cyc();
        chk("midplay_playing", 32'(playing), 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        @(negedge clock);
        check_all_zero("midreset");
        cyc();
        pulse_play(1'b0);
        cyc(3);
        chk("postreset_playing", 32'(playing), 0);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            reset           = ($urandom % 600) == 0;
            record_req      = ($urandom % 40) == 0;
            play_req        = ($urandom % 30) == 0;
            clip_sel_record = 1'($urandom);
            clip_sel_play   = 1'($urandom);
            sample_valid    = ($urandom % 3) == 0;
            sample_in       = SW'($urandom);
            play_tick       = ($urandom % 3) == 0;
            cyc();
        end
        reset = 1'b0; record_req = 1'b0; play_req = 1'b0;
        sample_valid = 1'b0; play_tick = 1'b0;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clip_sequencer.md
Name: clip_sequencer

Overview:
Sequences recording and playback for the two-clip audio recorder.
- Owns the shared BRAM address counter and the per-memory enable/write-enable strobes.
- Stores deserialized microphone samples into the selected clip memory, and streams the selected clip back out at the sample rate.
- Sits between the synchronizer/button logic, the deserializer, the two clip BRAMs and the audio output/LED path.

Parameters:
ADDR_W, 15, BRAM address width
CLIP_DEPTH, 32768, maximum samples per clip (must be <= 2**ADDR_W)
SAMPLE_W, 16, sample width

Ports:
clock  in  1  system (scaled) clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
record_req  in  1  one-cycle pulse, synchronized record button
play_req  in  1  one-cycle pulse, synchronized play button
clip_sel_record  in  1  clip targeted by record (0 = mem1, 1 = mem2), sampled on accepted record_req
clip_sel_play  in  1  clip targeted by play, sampled on accepted play_req
sample_valid  in  1  deserializer done pulse; sample_in valid this cycle
sample_in  in  SAMPLE_W  deserialized microphone sample
play_tick  in  1  sample-rate strobe for playback pacing
mem1_dout  in  SAMPLE_W  BRAM 1 read data (1-cycle read latency)
mem2_dout  in  SAMPLE_W  BRAM 2 read data
mem_addr  out  ADDR_W  shared BRAM address
mem_din  out  SAMPLE_W  shared BRAM write data
mem1_en  out  1  BRAM 1 enable
mem2_en  out  1  BRAM 2 enable
mem1_we  out  1  BRAM 1 write enable
mem2_we  out  1  BRAM 2 write enable
sample_out  out  SAMPLE_W  playback sample, held between valid pulses
sample_out_valid  out  1  one-cycle pulse, new sample_out
recording  out  1  high in RECORD
playing  out  1  high in PLAY
active_clip  out  1  clip currently being recorded or played
clip_full  out  2  bit i set when clip i+1 holds CLIP_DEPTH samples

Behaviour:
- Reset state: IDLE. All outputs 0. Address counter 0. Both stored clip lengths len[0], len[1] = 0.
- States: IDLE, RECORD, PLAY. Only one of recording/playing is ever high.
- IDLE:
  - record_req: latch clip_sel_record into active_clip, addr = 0, go to RECORD.
  - Else play_req with len[clip_sel_play] != 0: latch clip_sel_play, addr = 0, go to PLAY.
  - play_req on an empty clip: ignored.
  - record_req and play_req in the same cycle: record wins.
- RECORD:
  - Each sample_valid: same cycle, drive mem_addr = addr, mem_din = sample_in, memX_en = memX_we = 1 for active_clip only (combinational strobe, exactly one cycle per sample); addr increments next edge.
  - record_req: stops recording. len[active_clip] = addr (samples written, including one written the same cycle), go to IDLE.
  - Write of address CLIP_DEPTH-1: automatic stop. len = CLIP_DEPTH, clip_full bit set, go to IDLE.
  - play_req: ignored.
  - Recording a clip clears its clip_full bit at entry and overwrites its previous length.
- PLAY:
  - Each play_tick: memX_en = 1, memX_we = 0 for active_clip, mem_addr = addr.
  - Next cycle: sample_out <= memX_dout of active_clip, sample_out_valid = 1 (latency 1 cycle from tick). addr increments.
  - After the read of address len-1, its output pulse still occurs, then return to IDLE.
  - play_req: stops playback. Any read already issued still produces its sample_out_valid pulse next cycle. Go to IDLE.
  - record_req: ignored.
- sample_valid and play_tick are ignored outside RECORD and PLAY respectively.
- sample_out holds its last value in IDLE.
- The non-active memory never sees en or we asserted.
- Mid-operation reset: immediate return to reset state. Strobes deassert the same edge. Lengths lost.
- Address arithmetic is unsigned ADDR_W. The counter never wraps: auto-stop precedes overflow.

Test Plan:
- Reset, then record_req clip 0, 5 sample_valid pulses with values 0x0001..0x0005, then record_req → mem1_we pulses at addr 0..4 with matching mem_din; mem2_we never high; recording falls; len[0] = 5.
- After that, play_req clip 0 with play_tick every 4 cycles and BRAM model → sample_out_valid 5 times, values 0x0001..0x0005, each 1 cycle after its tick; playing drops after the 5th; then IDLE.
- play_req clip 1 while it is empty → stays IDLE, no en strobes, playing stays 0.
- record_req and play_req in the same IDLE cycle, clip_sel_record = 1 → RECORD on clip 1; play ignored.
- CLIP_DEPTH = 8 build, record clip 1 with 10 sample_valid pulses → exactly 8 writes at addr 0..7, auto-return to IDLE, clip_full = 2'b10, last 2 samples dropped.
- Reset asserted during PLAY mid-clip → next edge all outputs 0, state IDLE; subsequent play_req on clip 0 ignored (length cleared).
